// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, byte limit and FSM encoding for the data-memory access unit
package dmem_pkg;
  localparam int DMEM_ADDR_W = 11;
  localparam int DMEM_DATA_W = 32;
  localparam logic [31:0] DMEM_BYTE_LIMIT = 32'h2000;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/dmem_addr_check.sv
// dmem_addr_check: byte-to-word address conversion with misalignment and range flags
module dmem_addr_check
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic [31:0]       req_addr,
  output logic [ADDR_W-1:0] word_addr,
  output logic              err_mis,
  output logic              err_oor
);
  assign word_addr = req_addr[ADDR_W+1:2];
  assign err_mis   = |req_addr[1:0];
  assign err_oor   = |req_addr[31:ADDR_W+2];
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store sequencer in front of a single-port registered-read block RAM
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta
);
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] word_addr, addr_n;
  logic [DATA_W-1:0] din_n, rdata_n;
  logic err_mis, err_oor, accept, ena_n, wea_n, vld_n, err_n;
  dmem_addr_check #(.ADDR_W(ADDR_W)) u_chk (
    .req_addr (req_addr),
    .word_addr(word_addr),
    .err_mis  (err_mis),
    .err_oor  (err_oor)
  );
  assign req_ready = state == IDLE;
  assign accept    = req_valid && req_ready;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ena_n   = mem_ena;
    wea_n   = mem_wea;
    addr_n  = mem_addra;
    din_n   = mem_dina;
    rdata_n = rsp_rdata;
    vld_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (err_mis || err_oor) begin
          state_n = RESP;
          vld_n   = 1'b1;
          err_n   = 1'b1;
          rdata_n = '0;
        end else begin
          state_n = ISSUE;
          ena_n   = 1'b1;
          wea_n   = req_we;
          addr_n  = word_addr;
          din_n   = req_wdata;
        end
      end
      ISSUE: if (mem_wea) begin
        state_n = RESP;
        ena_n   = 1'b0;
        wea_n   = 1'b0;
        vld_n   = 1'b1;
        rdata_n = '0;
      end else begin
        state_n = WAIT;
        cnt_n   = 2'(RD_LATENCY - 1);
      end
      // ena stays high while waiting so the RAM keeps presenting the same word
      WAIT: if (cnt == 2'd0) begin
        state_n = RESP;
        ena_n   = 1'b0;
        vld_n   = 1'b1;
        rdata_n = mem_douta;
      end else begin
        cnt_n = cnt - 2'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clka) begin
    if (rsta) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_ena   <= 1'b0;
      mem_wea   <= 1'b0;
      mem_addra <= '0;
      mem_dina  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_ena   <= ena_n;
      mem_wea   <= wea_n;
      mem_addra <= addr_n;
      mem_dina  <= din_n;
      rsp_valid <= vld_n;
      rsp_err   <= err_n;
      rsp_rdata <= rdata_n;
    end
  end
endmodule
